// File: rtl/ccip_rd_credit_pkg.sv
// Shared definitions for the CCI-P channel 0 read-credit shim: header layout
// and the cl_len to cache-line cost mapping.
package ccip_rd_credit_pkg;

    localparam int HDR_WIDTH  = 74;
    localparam int CL_LEN_LSB = 68;
    localparam int CL_LEN_MSB = 69;

    typedef logic [HDR_WIDTH-1:0] t_rd_hdr;

    // The reserved encoding 2 is charged as a 4-line request so credits are never under-counted.
    function automatic logic [2:0] cl_len_to_lines(input logic [1:0] cl_len);
        case (cl_len)
            2'd0:    cl_len_to_lines = 3'd1;
            2'd1:    cl_len_to_lines = 3'd2;
            default: cl_len_to_lines = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ccip_rd_credit_fifo.sv
// Request buffer for the read-credit shim: registered-pointer synchronous FIFO
// with a registered almost-full flag derived from the next-state occupancy.
module ccip_rd_credit_fifo #(
    parameter int DEPTH         = 16,
    parameter int WIDTH         = 74,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             almfull_o,
    output logic             overflow_o
);

    localparam int PW         = $clog2(DEPTH);
    localparam int AF_INT     = DEPTH - ALMFULL_SLACK;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
    localparam logic [PW:0] AF_CNT   = AF_INT[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             almfull_q, almfull_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full;
    assign pop_ok     = pop_i && !empty_o;
    assign overflow_o = push_i && full;
    assign head_o     = mem_q[rd_ptr_q];
    assign almfull_o  = almfull_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        almfull_d = (count_d >= AF_CNT);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Almost-full resets high so the AFU is held off until the shim is out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            almfull_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            almfull_q <= almfull_d;
        end
    end

endmodule

// File: rtl/ccip_c0_rd_credit_shim.sv
// CCI-P c0 read-request throttle: buffers AFU reads and issues them only while
// the number of cache lines in flight stays within MAX_OUTSTANDING.
module ccip_c0_rd_credit_shim
    import ccip_rd_credit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int BUF_DEPTH       = 16,
    parameter int ALMFULL_SLACK   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 afu_c0tx_valid,
    input  logic [HDR_WIDTH-1:0] afu_c0tx_hdr,
    output logic                 afu_c0tx_almfull,
    output logic                 fiu_c0tx_valid,
    output logic [HDR_WIDTH-1:0] fiu_c0tx_hdr,
    input  logic                 fiu_c0tx_almfull,
    input  logic                 fiu_c0rx_rdvalid,
    output logic [9:0]           outstanding,
    output logic [31:0]          stall_cycles,
    output logic [1:0]           err_sticky
);

    // Flow control: afu_c0tx_valid is a one-cycle push with no ready; the AFU
    // must stop within ALMFULL_SLACK requests of afu_c0tx_almfull rising.
    // fiu_c0tx_valid is likewise a one-cycle strobe, only raised while
    // fiu_c0tx_almfull was low in the cycle before.

    localparam logic [10:0] MAX_C = MAX_OUTSTANDING[10:0];

    t_rd_hdr     fifo_head;
    logic        fifo_empty;
    logic        fifo_almfull;
    logic        fifo_overflow;

    logic [1:0]  head_cl_len;
    logic [2:0]  head_lines;
    logic [10:0] credit_sum;
    logic        credit_ok;
    logic        issue;
    logic        stall;
    logic        underflow;

    logic        fiu_valid_q, fiu_valid_d;
    t_rd_hdr     fiu_hdr_q, fiu_hdr_d;
    logic [9:0]  outstanding_q, outstanding_d;
    logic [31:0] stall_q, stall_d;
    logic [1:0]  err_q, err_d;

    ccip_rd_credit_fifo #(
        .DEPTH         (BUF_DEPTH),
        .WIDTH         (HDR_WIDTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (afu_c0tx_valid),
        .push_data_i (afu_c0tx_hdr),
        .pop_i       (issue),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .almfull_o   (fifo_almfull),
        .overflow_o  (fifo_overflow)
    );

    assign head_cl_len = fifo_head[CL_LEN_MSB:CL_LEN_LSB];
    assign head_lines  = cl_len_to_lines(head_cl_len);
    assign credit_sum  = {1'b0, outstanding_q} + {8'd0, head_lines};
    assign credit_ok   = (credit_sum <= MAX_C);
    assign issue       = !fifo_empty && !fiu_c0tx_almfull && credit_ok;
    assign stall       = !fifo_empty && !fiu_c0tx_almfull && !credit_ok;

    always_comb begin
        fiu_valid_d   = issue;
        fiu_hdr_d     = issue ? fifo_head : fiu_hdr_q;
        outstanding_d = outstanding_q;
        underflow     = 1'b0;
        // An issue and a returning line in the same cycle are netted together.
        if (issue) begin
            outstanding_d = outstanding_q + {7'd0, head_lines} - {9'd0, fiu_c0rx_rdvalid};
        end else if (fiu_c0rx_rdvalid) begin
            if (outstanding_q == '0) begin
                underflow = 1'b1;
            end else begin
                outstanding_d = outstanding_q - 10'd1;
            end
        end
        stall_d = stall_q;
        if (stall && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        err_d = err_q | {underflow, fifo_overflow};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fiu_valid_q   <= 1'b0;
            fiu_hdr_q     <= '0;
            outstanding_q <= '0;
            stall_q       <= '0;
            err_q         <= '0;
        end else begin
            fiu_valid_q   <= fiu_valid_d;
            fiu_hdr_q     <= fiu_hdr_d;
            outstanding_q <= outstanding_d;
            stall_q       <= stall_d;
            err_q         <= err_d;
        end
    end

    assign afu_c0tx_almfull = fifo_almfull;
    assign fiu_c0tx_valid   = fiu_valid_q;
    assign fiu_c0tx_hdr     = fiu_hdr_q;
    assign outstanding      = outstanding_q;
    assign stall_cycles     = stall_q;
    assign err_sticky       = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_credit_shim.sv
// Bench for ccip_c0_rd_credit_shim: vector table, directed corner sequences and
// random traffic, all checked against a queue-based model of the shim's rules.
module tb_ccip_c0_rd_credit_shim;
  import ccip_rd_credit_pkg::*;

  localparam int MAXO  = 64;
  localparam int DEPTH = 16;
  localparam int SLACK = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        afu_c0tx_valid = 1'b0;
  logic [73:0] afu_c0tx_hdr = '0;
  logic        afu_c0tx_almfull;
  logic        fiu_c0tx_valid;
  logic [73:0] fiu_c0tx_hdr;
  logic        fiu_c0tx_almfull = 1'b0;
  logic        fiu_c0rx_rdvalid = 1'b0;
  logic [9:0]  outstanding;
  logic [31:0] stall_cycles;
  logic [1:0]  err_sticky;

  ccip_c0_rd_credit_shim #(
    .MAX_OUTSTANDING(MAXO),
    .BUF_DEPTH(DEPTH),
    .ALMFULL_SLACK(SLACK)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .afu_c0tx_valid(afu_c0tx_valid),
    .afu_c0tx_hdr(afu_c0tx_hdr),
    .afu_c0tx_almfull(afu_c0tx_almfull),
    .fiu_c0tx_valid(fiu_c0tx_valid),
    .fiu_c0tx_hdr(fiu_c0tx_hdr),
    .fiu_c0tx_almfull(fiu_c0tx_almfull),
    .fiu_c0rx_rdvalid(fiu_c0rx_rdvalid),
    .outstanding(outstanding),
    .stall_cycles(stall_cycles),
    .err_sticky(err_sticky)
  );

  int total = 0;
  int bad = 0;

  // reference model: buffered requests, lines in flight, counters
  logic [73:0] exp_q[$];
  int          m_out;
  logic        m_valid;
  logic [73:0] m_hdr;
  logic [31:0] m_stall;
  logic [1:0]  m_err;
  logic        m_af;
  logic [73:0] last_hdr;

  typedef struct {
    logic       v;
    logic [1:0] cl;
    logic       faf;
    logic       rd;
    logic       e_valid;
    int         e_out;
  } vec_t;
  vec_t tbl[10];

  function automatic int lines_of(input logic [1:0] cl);
    return (cl == 2'd2) ? 4 : int'(cl) + 1;
  endfunction

  function automatic logic [73:0] mk_hdr(input logic [1:0] cl);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    r[69:68] = cl;
    return r[73:0];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_out = 0;
    m_valid = 1'b0;
    m_hdr = '0;
    m_stall = '0;
    m_err = '0;
    m_af = 1'b1;
  endtask

  task automatic compare_model();
    check("valid", 128'(fiu_c0tx_valid), 128'(m_valid));
    check("hdr", 128'(fiu_c0tx_hdr), 128'(m_hdr));
    check("outstanding", 128'(outstanding), 128'(m_out));
    check("afu_almfull", 128'(afu_c0tx_almfull), 128'(m_af));
    check("stall_cycles", 128'(stall_cycles), 128'(m_stall));
    check("err_sticky", 128'(err_sticky), 128'(m_err));
  endtask

  // driver: one clock cycle of stimulus, model update, then compare after the edge
  task automatic step(input logic v, input logic [1:0] cl, input logic faf, input logic rd);
    logic [73:0] h;
    int          sz;
    int          hl;
    bit          iss;
    h = mk_hdr(cl);
    last_hdr = h;
    afu_c0tx_valid = v;
    afu_c0tx_hdr = h;
    fiu_c0tx_almfull = faf;
    fiu_c0rx_rdvalid = rd;
    sz = exp_q.size();
    iss = 1'b0;
    hl = 0;
    if (sz > 0 && !faf) begin
      hl = lines_of(exp_q[0][69:68]);
      if (m_out + hl <= MAXO) iss = 1'b1;
      else if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    m_valid = iss;
    if (iss) begin
      m_hdr = exp_q.pop_front();
      m_out += hl;
    end
    if (rd) begin
      if (m_out == 0) m_err[1] = 1'b1;
      else m_out--;
    end
    if (v) begin
      if (sz == DEPTH) m_err[0] = 1'b1;
      else exp_q.push_back(h);
    end
    m_af = (exp_q.size() >= DEPTH - SLACK);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && m_out > 0; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    check("drain_out", 128'(outstanding), 128'(0));
  endtask

  // asynchronous reset asserted between edges, checked before the next edge
  task automatic reset_pulse();
    #3;
    reset_n = 1'b0;
    afu_c0tx_valid = 1'b0;
    fiu_c0tx_almfull = 1'b0;
    fiu_c0rx_rdvalid = 1'b0;
    #1;
    check("rst_valid", 128'(fiu_c0tx_valid), 128'(0));
    check("rst_hdr", 128'(fiu_c0tx_hdr), 128'(0));
    check("rst_out", 128'(outstanding), 128'(0));
    check("rst_stall", 128'(stall_cycles), 128'(0));
    check("rst_err", 128'(err_sticky), 128'(0));
    check("rst_almfull", 128'(afu_c0tx_almfull), 128'(1));
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("post_rst_almfull", 128'(afu_c0tx_almfull), 128'(0));
  endtask

  initial begin
    int n_iss;
    logic [73:0] h1;
    logic [31:0] s0;

    tbl[0] = '{v:1, cl:0, faf:0, rd:0, e_valid:0, e_out:0};
    tbl[1] = '{v:1, cl:3, faf:0, rd:0, e_valid:1, e_out:1};
    tbl[2] = '{v:0, cl:0, faf:0, rd:0, e_valid:1, e_out:5};
    tbl[3] = '{v:0, cl:0, faf:0, rd:1, e_valid:0, e_out:4};
    tbl[4] = '{v:1, cl:1, faf:1, rd:0, e_valid:0, e_out:4};
    tbl[5] = '{v:0, cl:0, faf:1, rd:0, e_valid:0, e_out:4};
    tbl[6] = '{v:0, cl:0, faf:0, rd:1, e_valid:1, e_out:5};
    tbl[7] = '{v:0, cl:0, faf:0, rd:1, e_valid:0, e_out:4};
    tbl[8] = '{v:1, cl:2, faf:0, rd:0, e_valid:0, e_out:4};
    tbl[9] = '{v:0, cl:0, faf:0, rd:0, e_valid:1, e_out:8};

    model_clear();
    #11;
    reset_pulse();

    // vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].cl, tbl[i].faf, tbl[i].rd);
      check($sformatf("tbl%0d_valid", i), 128'(fiu_c0tx_valid), 128'(tbl[i].e_valid));
      check($sformatf("tbl%0d_out", i), 128'(outstanding), 128'(tbl[i].e_out));
    end
    drain();
    reset_pulse();

    // single request latency and header integrity
    step(1'b1, 2'd0, 1'b0, 1'b0);
    h1 = last_hdr;
    check("lat_edge0_valid", 128'(fiu_c0tx_valid), 128'(0));
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("lat_edge1_valid", 128'(fiu_c0tx_valid), 128'(1));
    check("lat_hdr", 128'(fiu_c0tx_hdr), 128'(h1));
    check("lat_out1", 128'(outstanding), 128'(1));
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("lat_out0", 128'(outstanding), 128'(0));
    check("lat_valid_drop", 128'(fiu_c0tx_valid), 128'(0));

    // credit exhaustion with 4-line requests
    for (int i = 0; i < 17; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
    check("cred_out64", 128'(outstanding), 128'(64));
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("cred_stall1", 128'(stall_cycles), 128'(1));
    check("cred_no_issue", 128'(fiu_c0tx_valid), 128'(0));
    s0 = stall_cycles;
    idle(2);
    check("cred_stall_inc", 128'(stall_cycles), 128'(s0 + 32'd2));
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    check("cred_out60", 128'(outstanding), 128'(60));
    check("cred_stall7", 128'(stall_cycles), 128'(7));
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("cred_17th_valid", 128'(fiu_c0tx_valid), 128'(1));
    check("cred_out64b", 128'(outstanding), 128'(64));
    drain();
    reset_pulse();

    // issue and response in the same cycle are netted
    for (int i = 0; i < 10; i++) step(1'b1, 2'd0, 1'b0, 1'b0);
    idle(2);
    check("net_out10", 128'(outstanding), 128'(10));
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("net_valid", 128'(fiu_c0tx_valid), 128'(1));
    check("net_out11", 128'(outstanding), 128'(11));
    drain();
    reset_pulse();

    // MPF back-pressure fills the buffer up to the almost-full threshold
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 1'b1, 1'b0);
      check($sformatf("af_push%0d", i), 128'(afu_c0tx_almfull), 128'(i == 7));
      check("af_no_issue", 128'(fiu_c0tx_valid), 128'(0));
    end
    check("af_stall0", 128'(stall_cycles), 128'(0));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0);
      check("af_release_issue", 128'(fiu_c0tx_valid), 128'(1));
    end
    check("af_out8", 128'(outstanding), 128'(8));
    check("af_clear", 128'(afu_c0tx_almfull), 128'(0));
    drain();
    reset_pulse();

    // overflow then underflow
    for (int i = 0; i < 17; i++) step(1'b1, 2'd0, 1'b1, 1'b0);
    check("ovf_err", 128'(err_sticky), 128'(2'b01));
    n_iss = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0);
      if (fiu_c0tx_valid) n_iss++;
    end
    check("ovf_issued16", 128'(n_iss), 128'(16));
    drain();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("udf_err", 128'(err_sticky), 128'(2'b11));
    check("udf_out0", 128'(outstanding), 128'(0));
    reset_pulse();

    // reset in the middle of a burst
    for (int i = 0; i < 21; i++) step(1'b1, 2'd0, 1'b0, 1'b0);
    check("mid_out20", 128'(outstanding), 128'(20));
    reset_pulse();
    check("mid_empty_valid", 128'(fiu_c0tx_valid), 128'(0));
    check("mid_out0", 128'(outstanding), 128'(0));
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("mid_late_rsp", 128'(err_sticky), 128'(2'b10));
    reset_pulse();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic v, faf, rd;
      v   = ($urandom_range(0, 99) < 60);
      faf = ($urandom_range(0, 99) < 15);
      rd  = (m_out > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
      step(v, 2'($urandom_range(0, 3)), faf, rd);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ccip_c0_rd_credit_shim.md
Name: ccip_c0_rd_credit_shim

Overview:
- Read-request throttle on CCI-P channel 0, sitting between the NLB AFU's c0 Tx output and the MPF afu-side c0 Tx input, in the afu_clk domain.
- Buffers read requests in a small FIFO and issues them only when the outstanding-line count stays within MAX_OUTSTANDING.
- Returns one credit per read response line, so the AFU cannot oversubscribe MPF read-response sorting.

Parameters:
- MAX_OUTSTANDING, 64: maximum cache lines in flight. Power of two, 8..512.
- BUF_DEPTH, 16: request FIFO entries. Power of two, >= 16.
- ALMFULL_SLACK, 8: free entries remaining when afu_c0tx_almfull asserts. CCI-P allows 8 requests after almost-full.

Ports:
- clk  in  1  afu_clk
- reset_n  in  1  asynchronous, active-low reset
- afu_c0tx_valid  in  1  AFU read request valid
- afu_c0tx_hdr  in  74  t_ccip_c0_ReqMemHdr from AFU
- afu_c0tx_almfull  out  1  back-pressure to AFU
- fiu_c0tx_valid  out  1  registered request toward MPF
- fiu_c0tx_hdr  out  74  registered header toward MPF
- fiu_c0tx_almfull  in  1  MPF c0TxAlmFull
- fiu_c0rx_rdvalid  in  1  one read-response line returned
- outstanding  out  10  lines currently in flight
- stall_cycles  out  32  saturating count of credit-stalled cycles
- err_sticky  out  2  bit0 FIFO overflow, bit1 response underflow

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - All outputs 0, except afu_c0tx_almfull = 1 while reset_n is low.
  - afu_c0tx_almfull = 0 on the first cycle after deassertion.
  - FIFO empty.
- Line cost of a request: len = hdr.cl_len + 1 (cl_len 0 → 1 line, 1 → 2, 3 → 4). cl_len 2 is treated as 3 (cost 4).
- Push: afu_c0tx_valid writes the header into the FIFO at the clock edge.
  - A push while the FIFO is full drops the request and sets err_sticky[0].
- afu_c0tx_almfull is registered, = (fifo_count >= BUF_DEPTH - ALMFULL_SLACK), computed from the next-state count.
- Issue condition, evaluated each cycle: FIFO non-empty AND !fiu_c0tx_almfull AND outstanding + len_head <= MAX_OUTSTANDING. At most one issue per cycle.
- On issue:
  - Pop the head.
  - Register fiu_c0tx_valid = 1 and fiu_c0tx_hdr = head for the next cycle.
  - Otherwise fiu_c0tx_valid = 0 and fiu_c0tx_hdr holds its last value.
- Latency: with the FIFO empty and credits available, a request pushed at edge N appears on fiu_c0tx_valid after edge N+1 (2-cycle latency).
- Throughput: 1 request per cycle when unstalled.
- outstanding update: outstanding_next = outstanding + (issue ? len : 0) - (rdvalid ? 1 : 0).
  - Simultaneous issue and response are netted in the same cycle.
  - rdvalid when outstanding == 0 and no issue: outstanding stays 0 and err_sticky[1] is set.
- stall_cycles increments when the FIFO is non-empty, fiu_c0tx_almfull = 0, and the credit check fails. Saturates at 0xFFFFFFFF.
- FIFO pointers are log2(BUF_DEPTH) bits and wrap naturally; count has one extra bit.
- Reset mid-operation: FIFO contents discarded; outstanding, counters and errors cleared. Responses to already-issued requests that arrive after reset are counted as underflow.
- err_sticky clears only on reset.

Decomposition:
- Package ccip_rd_credit_pkg holds:
  - header field offsets CL_LEN_LSB = 68 and CL_LEN_MSB = 69;
  - HDR_WIDTH = 74;
  - function cl_len_to_lines(), returning a 3-bit line count.
- Sub-module ccip_rd_credit_fifo: registered-pointer synchronous FIFO (storage, count, full/empty, almfull threshold). The top level holds the credit logic, issue register and counters.

Test Plan:
- Single request, cl_len = 0, no stall → fiu_c0tx_valid high exactly 2 cycles after push, hdr bit-identical, outstanding = 1; one rdvalid → outstanding = 0.
- MAX_OUTSTANDING = 64: push 17 requests with cl_len = 3 back-to-back → 16 issue; the 17th waits with stall_cycles incrementing; 4 rdvalids → the 17th issues the next cycle, outstanding = 64.
- Issue (cl_len = 1) and rdvalid in the same cycle with outstanding = 10 → outstanding = 11.
- Hold fiu_c0tx_almfull = 1 while pushing 8 requests → afu_c0tx_almfull asserts after the 8th push (count 8); no fiu_c0tx_valid; stall_cycles unchanged. Release → 8 consecutive issues.
- Push 17 requests into the 16-deep FIFO with the fiu blocked → err_sticky = 2'b01 and only 16 requests later issue. A rdvalid with outstanding = 0 → err_sticky = 2'b11.
- Assert reset_n low mid-burst with outstanding = 20 → all outputs 0 asynchronously and afu_c0tx_almfull = 1; after release the FIFO is empty and outstanding = 0.
